ad7991_i2c_responder: RTL and testbench

AD7991_I2C_RESPONDER -- requirements
Module: ad7991_i2c_responder

---
 rtl/ad7991_i2c_responder.sv | 268 ++++++++++++++++++++++++++
 tb/tb_ad7991_i2c_responder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad7991_i2c_responder.sv
// AD7991-style I2C slave emulator. It answers at SLAVE_ADDR, accepts
// configuration bytes, and streams 16-bit conversion words for the
// channels selected in cfg[7:4]. SDA is open-drain and SCL is never stretched.
module ad7991_i2c_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [11:0] ch0_data,
  input  logic [11:0] ch1_data,
  input  logic [11:0] ch2_data,
  input  logic [11:0] ch3_data,
  output logic [7:0]  cfg,
  output logic        cfg_wr,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  // An empty channel set falls back to VIN0 alone.
  function automatic logic [3:0] chanSetOf(input logic [3:0] nib);
    return (nib == 4'b0000) ? 4'b0001 : nib;
  endfunction

  function automatic logic [1:0] lowestChan(input logic [3:0] set);
    logic [1:0] res;
    res = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (set[i]) res = i[1:0];
    end
    return res;
  endfunction

  // Walks offsets 3..1 so the smallest ascending offset wins. If no other
  // channel is selected, the pointer stays where it is.
  function automatic logic [1:0] nextChan(input logic [3:0] set, input logic [1:0] cur);
    logic [1:0] res;
    logic [1:0] cand;
    res = cur;
    for (int i = 3; i >= 1; i--) begin
      cand = cur + i[1:0];
      if (set[cand]) res = cand;
    end
    return res;
  endfunction

  logic        sclMeta_q, sclSync_q, sclPrev_q;
  logic        sdaMeta_q, sdaSync_q, sdaPrev_q;
  logic        fallDly_q;
  logic        sclRise, sclFall, startDet, stopDet;

  state_t      state_q, state_d;
  logic [3:0]  bitCnt_q, bitCnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        rw_q, rw_d;
  logic        sdaOe_q, sdaOe_d;
  logic        busy_q, busy_d;
  logic [7:0]  cfg_q, cfg_d;
  logic        cfgWr_q, cfgWr_d;
  logic [1:0]  chPtr_q, chPtr_d;
  logic [15:0] word_q, word_d;
  logic        lowByte_q, lowByte_d;
  logic        ackBit_q, ackBit_d;

  logic [11:0] chSample [4];
  logic [1:0]  ptrNext;
  logic [15:0] snapWord, nextWord;
  logic [7:0]  txByte;
  logic        txBit;

  assign chSample[0] = ch0_data;
  assign chSample[1] = ch1_data;
  assign chSample[2] = ch2_data;
  assign chSample[3] = ch3_data;

  assign ptrNext  = nextChan(chanSetOf(cfg_q[7:4]), chPtr_q);
  assign snapWord = {2'b00, chPtr_q, chSample[chPtr_q]};
  assign nextWord = {2'b00, ptrNext, chSample[ptrNext]};
  assign txByte   = lowByte_q ? word_q[7:0] : word_q[15:8];
  assign txBit    = txByte[3'd7 - bitCnt_q[2:0]];

  assign sclRise  = sclSync_q & ~sclPrev_q;
  assign sclFall  = ~sclSync_q & sclPrev_q;
  assign startDet = sclSync_q & sclPrev_q & sdaPrev_q & ~sdaSync_q;
  assign stopDet  = sclSync_q & sclPrev_q & ~sdaPrev_q & sdaSync_q;

  // Bring the bus pins into the clock domain and keep one-cycle history for edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclMeta_q <= 1'b1;
      sclSync_q <= 1'b1;
      sclPrev_q <= 1'b1;
      sdaMeta_q <= 1'b1;
      sdaSync_q <= 1'b1;
      sdaPrev_q <= 1'b1;
      fallDly_q <= 1'b0;
    end else begin
      sclMeta_q <= scl_in;
      sclSync_q <= sclMeta_q;
      sclPrev_q <= sclSync_q;
      sdaMeta_q <= sda_in;
      sdaSync_q <= sdaMeta_q;
      sdaPrev_q <= sdaSync_q;
      fallDly_q <= sclFall;
    end
  end

  // Protocol state register; async reset releases SDA at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bitCnt_q  <= 4'd0;
      shift_q   <= 8'h00;
      rw_q      <= 1'b0;
      sdaOe_q   <= 1'b0;
      busy_q    <= 1'b0;
      cfg_q     <= 8'hF0;
      cfgWr_q   <= 1'b0;
      chPtr_q   <= 2'd0;
      word_q    <= 16'h0000;
      lowByte_q <= 1'b0;
      ackBit_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
      rw_q      <= rw_d;
      sdaOe_q   <= sdaOe_d;
      busy_q    <= busy_d;
      cfg_q     <= cfg_d;
      cfgWr_q   <= cfgWr_d;
      chPtr_q   <= chPtr_d;
      word_q    <= word_d;
      lowByte_q <= lowByte_d;
      ackBit_q  <= ackBit_d;
    end
  end

  // Next-state logic: sample on SCL rise, change SDA the cycle after SCL fall.
  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    rw_d      = rw_q;
    sdaOe_d   = sdaOe_q;
    busy_d    = busy_q;
    cfg_d     = cfg_q;
    cfgWr_d   = 1'b0;
    chPtr_d   = chPtr_q;
    word_d    = word_q;
    lowByte_d = lowByte_q;
    ackBit_d  = ackBit_q;

    if (startDet) begin
      state_d  = ADDR;
      bitCnt_d = 4'd0;
      sdaOe_d  = 1'b0;
    end else if (stopDet) begin
      state_d = IDLE;
      sdaOe_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (sclRise) begin
            shift_d  = {shift_q[6:0], sdaSync_q};
            bitCnt_d = bitCnt_q + 4'd1;
          end else if (fallDly_q && bitCnt_q == 4'd8) begin
            bitCnt_d = 4'd0;
            if (shift_q[7:1] == SLAVE_ADDR) begin
              state_d = ADDR_ACK;
              rw_d    = shift_q[0];
              busy_d  = 1'b1;
              sdaOe_d = 1'b1;
            end else begin
              state_d = WAIT_STOP;
              busy_d  = 1'b0;
              sdaOe_d = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (fallDly_q) begin
            bitCnt_d = 4'd0;
            if (rw_q) begin
              state_d   = RD_BYTE;
              word_d    = snapWord;
              lowByte_d = 1'b0;
              sdaOe_d   = ~snapWord[15];
            end else begin
              state_d = WR_BYTE;
              sdaOe_d = 1'b0;
            end
          end
        end
        WR_BYTE: begin
          if (sclRise) begin
            shift_d  = {shift_q[6:0], sdaSync_q};
            bitCnt_d = bitCnt_q + 4'd1;
          end else if (fallDly_q && bitCnt_q == 4'd8) begin
            cfg_d    = shift_q;
            cfgWr_d  = 1'b1;
            chPtr_d  = lowestChan(chanSetOf(shift_q[7:4]));
            state_d  = WR_ACK;
            sdaOe_d  = 1'b1;
            bitCnt_d = 4'd0;
          end
        end
        WR_ACK: begin
          if (fallDly_q) begin
            state_d = WR_BYTE;
            sdaOe_d = 1'b0;
          end
        end
        RD_BYTE: begin
          if (sclRise) begin
            bitCnt_d = bitCnt_q + 4'd1;
          end else if (fallDly_q) begin
            if (bitCnt_q == 4'd8) begin
              state_d  = RD_ACK;
              sdaOe_d  = 1'b0;
              bitCnt_d = 4'd0;
            end else begin
              sdaOe_d = ~txBit;
            end
          end
        end
        RD_ACK: begin
          if (sclRise) begin
            ackBit_d = sdaSync_q;
          end else if (fallDly_q) begin
            if (ackBit_q) begin
              state_d = WAIT_STOP;
              sdaOe_d = 1'b0;
            end else if (!lowByte_q) begin
              state_d   = RD_BYTE;
              lowByte_d = 1'b1;
              sdaOe_d   = ~word_q[7];
            end else begin
              state_d   = RD_BYTE;
              chPtr_d   = ptrNext;
              word_d    = nextWord;
              lowByte_d = 1'b0;
              sdaOe_d   = ~nextWord[15];
            end
          end
        end
        WAIT_STOP: sdaOe_d = 1'b0;
        default: begin
          state_d = IDLE;
          sdaOe_d = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe = sdaOe_q;
  assign cfg    = cfg_q;
  assign cfg_wr = cfgWr_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_ad7991_i2c_responder.sv
// Bench for ad7991_i2c_responder: a bit-banged I2C master drives the bus
// and a channel-list model predicts the bytes returned on each read.
module tb_ad7991_i2c_responder;

  localparam logic [6:0] ADDR7 = 7'h28;

  logic        clk = 1'b0;
  logic        rst;
  logic        scl;
  logic        sdaMaster;
  logic        sdaOe;
  logic        sdaBus;
  logic [11:0] chData [4];
  logic [7:0]  cfgOut;
  logic        cfgWr;
  logic        busyOut;

  int quarter = 10;
  int checks = 0;
  int passed = 0;
  int cfgWrCount = 0;
  int oeCount = 0;
  int busyCount = 0;
  int oeViolations = 0;
  logic prevOe = 1'b0;

  logic [7:0] tbCfg;
  int         tbPtr;
  logic [7:0] expQ [$];

  assign sdaBus = sdaMaster & ~sdaOe;

  always #5 clk = ~clk;

  ad7991_i2c_responder #(.SLAVE_ADDR(ADDR7)) dut (
    .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sdaBus), .sda_oe(sdaOe),
    .ch0_data(chData[0]), .ch1_data(chData[1]), .ch2_data(chData[2]), .ch3_data(chData[3]),
    .cfg(cfgOut), .cfg_wr(cfgWr), .busy(busyOut)
  );

  // Watch the bus between clock edges: cfg_wr pulses, SDA drive, busy, and SDA pulled while SCL high.
  always @(negedge clk) begin
    if (cfgWr === 1'b1) cfgWrCount++;
    if (sdaOe === 1'b1) oeCount++;
    if (busyOut === 1'b1) busyCount++;
    if (sdaOe === 1'b1 && prevOe !== 1'b1 && scl === 1'b1) oeViolations++;
    prevOe = sdaOe;
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic qwait();
    repeat (quarter) @(posedge clk);
  endtask

  task automatic applyStimulus(input logic sclVal, input logic sdaVal);
    scl = sclVal;
    sdaMaster = sdaVal;
    qwait();
  endtask

  task automatic sendBit(input logic b);
    applyStimulus(1'b0, b);
    applyStimulus(1'b1, b);
    applyStimulus(1'b1, b);
    applyStimulus(1'b0, b);
  endtask

  task automatic recvBit(output logic b);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    b = sdaBus;
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
  endtask

  task automatic i2cStart();
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic i2cStop();
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
  endtask

  task automatic writeByte(input logic [7:0] b, output logic acked);
    logic bitVal;
    for (int i = 7; i >= 0; i--) sendBit(b[i]);
    recvBit(bitVal);
    acked = ~bitVal;
  endtask

  task automatic readByte(input logic ackIt, output logic [7:0] d);
    logic bitVal;
    for (int i = 7; i >= 0; i--) begin
      recvBit(bitVal);
      d[i] = bitVal;
    end
    sendBit(ackIt ? 1'b0 : 1'b1);
  endtask

  // Reference model: selected channels form an ascending list, walked cyclically.
  function automatic int modelLowest(input logic [7:0] c);
    for (int ch = 0; ch < 4; ch++) begin
      if (c[7:4] == 4'b0000) return 0;
      if (c[4 + ch]) return ch;
    end
    return 0;
  endfunction

  function automatic int modelNext(input logic [7:0] c, input int cur);
    int list [$];
    int idx;
    idx = 0;
    for (int ch = 0; ch < 4; ch++) begin
      if (c[4 + ch] || (c[7:4] == 4'b0000 && ch == 0)) list.push_back(ch);
    end
    foreach (list[k]) if (list[k] == cur) idx = k;
    return list[(idx + 1) % list.size()];
  endfunction

  task automatic buildExpected(input int n);
    int ch;
    logic [15:0] w;
    expQ.delete();
    ch = tbPtr;
    for (int i = 0; i < n; i += 2) begin
      w = {2'b00, 2'(ch), chData[ch]};
      expQ.push_back(w[15:8]);
      if (i + 1 < n) expQ.push_back(w[7:0]);
      ch = modelNext(tbCfg, ch);
    end
    for (int k = 0; k < (n - 1) / 2; k++) tbPtr = modelNext(tbCfg, tbPtr);
  endtask

  task automatic writeCfg(input logic [7:0] c, input logic thenStop);
    logic a;
    i2cStart();
    writeByte({ADDR7, 1'b0}, a);
    checkOutput("cfg addr ack", 16'(a), 16'd1);
    writeByte(c, a);
    checkOutput("cfg data ack", 16'(a), 16'd1);
    if (thenStop) i2cStop();
    tbCfg = c;
    tbPtr = modelLowest(c);
  endtask

  task automatic readFrame(input int n);
    logic a;
    logic [7:0] d;
    i2cStart();
    writeByte({ADDR7, 1'b1}, a);
    checkOutput("read addr ack", 16'(a), 16'd1);
    buildExpected(n);
    for (int i = 0; i < n; i++) begin
      readByte(i < n - 1, d);
      checkOutput($sformatf("read byte %0d", i), 16'(d), 16'(expQ[i]));
    end
    i2cStop();
    checkOutput("busy after stop", 16'(busyOut), 16'd0);
  endtask

  initial begin
    logic a;
    logic [7:0] d;
    int wrBase, oeBase, busyBase;
    logic [7:0] cfgBefore;

    rst = 1'b0;
    scl = 1'b1;
    sdaMaster = 1'b1;
    for (int k = 0; k < 4; k++) chData[k] = 12'h000;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("reset sda_oe", 16'(sdaOe), 16'd0);
    checkOutput("reset busy", 16'(busyOut), 16'd0);
    checkOutput("reset cfg", 16'(cfgOut), 16'h00F0);
    checkOutput("reset cfg_wr", 16'(cfgWr), 16'd0);
    rst = 1'b1;
    tbCfg = 8'hF0;
    tbPtr = 0;
    repeat (5) @(posedge clk);

    // Configuration write at 100 kHz SCL.
    quarter = 250;
    wrBase = cfgWrCount;
    i2cStart();
    writeByte(8'h50, a);
    checkOutput("w100k addr ack", 16'(a), 16'd1);
    checkOutput("w100k busy", 16'(busyOut), 16'd1);
    writeByte(8'h10, a);
    checkOutput("w100k data ack", 16'(a), 16'd1);
    i2cStop();
    checkOutput("w100k cfg", 16'(cfgOut), 16'h0010);
    checkOutput("w100k cfg_wr pulses", 16'(cfgWrCount - wrBase), 16'd1);
    checkOutput("w100k busy after stop", 16'(busyOut), 16'd0);
    tbCfg = 8'h10;
    tbPtr = modelLowest(8'h10);
    quarter = 10;

    // Two-byte read of VIN0.
    chData[0] = 12'hABC;
    readFrame(2);

    // Two selected channels, six bytes, wrap back to the lowest.
    writeCfg(8'hA0, 1'b1);
    chData[1] = 12'h123;
    chData[3] = 12'h456;
    readFrame(6);

    // Foreign address: no drive, no busy, cfg untouched.
    cfgBefore = cfgOut;
    oeBase = oeCount;
    busyBase = busyCount;
    i2cStart();
    writeByte({7'h2A, 1'b1}, a);
    checkOutput("foreign addr ack", 16'(a), 16'd0);
    i2cStop();
    checkOutput("foreign sda_oe", 16'(oeCount - oeBase), 16'd0);
    checkOutput("foreign busy", 16'(busyCount - busyBase), 16'd0);
    checkOutput("foreign cfg", 16'(cfgOut), 16'(cfgBefore));

    // Sample held across the word even though the input changes.
    writeCfg(8'h10, 1'b1);
    chData[0] = 12'hFFF;
    i2cStart();
    writeByte({ADDR7, 1'b1}, a);
    checkOutput("snap addr ack", 16'(a), 16'd1);
    buildExpected(2);
    readByte(1'b1, d);
    checkOutput("snap high", 16'(d), 16'(expQ[0]));
    chData[0] = 12'h000;
    readByte(1'b0, d);
    checkOutput("snap low", 16'(d), 16'(expQ[1]));
    i2cStop();

    // Reset in the middle of a high byte.
    chData[0] = 12'($urandom);
    i2cStart();
    writeByte({ADDR7, 1'b1}, a);
    checkOutput("rstmid addr ack", 16'(a), 16'd1);
    recvBit(a);
    recvBit(a);
    checkOutput("rstmid driving", 16'(sdaOe), 16'd1);
    rst = 1'b0;
    #1;
    checkOutput("rstmid sda_oe", 16'(sdaOe), 16'd0);
    checkOutput("rstmid cfg", 16'(cfgOut), 16'h00F0);
    checkOutput("rstmid busy", 16'(busyOut), 16'd0);
    repeat (3) @(posedge clk);
    rst = 1'b1;
    tbCfg = 8'hF0;
    tbPtr = 0;
    repeat (3) @(posedge clk);
    readFrame(2);

    // Randomized configurations, channel data and read lengths.
    for (int iter = 0; iter < 8; iter++) begin
      int mode;
      int n;
      logic [7:0] c;
      c = 8'($urandom);
      mode = $urandom_range(0, 2);
      n = $urandom_range(1, 6);
      for (int k = 0; k < 4; k++) chData[k] = 12'($urandom);
      if (mode == 0) writeCfg(c, 1'b1);
      else if (mode == 1) writeCfg(c, 1'b0);
      readFrame(n);
      checkOutput("rand cfg", 16'(cfgOut), 16'(tbCfg));
    end

    checkOutput("sda_oe rose with SCL high", 16'(oeViolations), 16'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
